// File: rtl/synth_pkg.sv
// Shared constants and helpers for the four-key tone generator.
// Tuning words are f*2^24/48000 for a 24-bit phase at 48 kHz.
package synth_pkg;

  localparam int N_KEYS    = 4;
  localparam int DAC_MID   = 2048;
  localparam int VOICE_AMP = 511;

  localparam logic [23:0] TUNE_C4 = 24'd91447;
  localparam logic [23:0] TUNE_E4 = 24'd115216;
  localparam logic [23:0] TUNE_G4 = 24'd137019;
  localparam logic [23:0] TUNE_C5 = 24'd182895;

  typedef enum logic [1:0] {
    KEY_C4 = 2'd0,
    KEY_E4 = 2'd1,
    KEY_G4 = 2'd2,
    KEY_C5 = 2'd3
  } key_idx_e;

  function automatic logic [23:0] tune_of(
    input key_idx_e k
  );
    logic [23:0] t;
    t = TUNE_C4;
    case (k)
      KEY_C4:  t = TUNE_C4;
      KEY_E4:  t = TUNE_E4;
      KEY_G4:  t = TUNE_G4;
      KEY_C5:  t = TUNE_C5;
      default: t = TUNE_C4;
    endcase
    return t;
  endfunction

  // Signed contribution of one voice to the mix.
  function automatic int voice_term(
    input logic on,
    input logic msb
  );
    int v;
    v = 0;
    if (on) begin
      v = msb ? -VOICE_AMP : VOICE_AMP;
    end
    return v;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchronizer followed by a stability counter.
// Output follows the synced key only after it differs for DEBOUNCE_CYC cycles.
module key_debounce
  import synth_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic key_db
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [1:0]       sync_ff;
  logic             synced;
  logic [CNT_W-1:0] cnt;

  assign synced = sync_ff[1];

  // Bring the asynchronous switch into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= 2'b00;
    end else begin
      sync_ff <= {sync_ff[0], key};
    end
  end

  // Accept a new level only after it has been stable long enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      key_db <= 1'b0;
    end else if (synced == key_db) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt    <= '0;
      key_db <= synced;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/key_tone_gen.sv
// Four-key square-wave synth: debounce, phase accumulators, mixer,
// and a valid/ready sample register feeding the DAC serializer.
module key_tone_gen
  import synth_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int SAMPLE_HZ    = 48_000,
  parameter int DEBOUNCE_CYC = 500_000,
  parameter int PHASE_W      = 24,
  parameter int SAMPLE_W     = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          keys,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic [3:0]          keys_db,
  output logic                overrun
);

  localparam int DIV   = CLK_HZ / SAMPLE_HZ;
  localparam int TCK_W = $clog2(DIV);
  localparam logic [TCK_W-1:0] TCK_LAST = TCK_W'(DIV - 1);
  localparam logic [SAMPLE_W-1:0] MID = SAMPLE_W'(DAC_MID);

  logic [1:0]          rst_ff;
  logic                rst_sync_n;
  logic [TCK_W-1:0]    tck_cnt;
  logic                tick;
  logic [PHASE_W-1:0]  phase [N_KEYS];
  logic                mix_pend;
  logic [SAMPLE_W-1:0] mix;

  // Assert asynchronously, release on a clean edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_ff <= 2'b00;
    end else begin
      rst_ff <= {rst_ff[0], 1'b1};
    end
  end

  assign rst_sync_n = rst_ff[1];

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_db (
      .clk    (clk),
      .rst_n  (rst_sync_n),
      .key    (keys[k]),
      .key_db (keys_db[k])
    );
  end

  assign tick = (tck_cnt == TCK_LAST);

  // Sample-rate divider.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      tck_cnt <= '0;
    end else if (tick) begin
      tck_cnt <= '0;
    end else begin
      tck_cnt <= tck_cnt + 1'b1;
    end
  end

  // Advance held voices; released voices park at phase 0.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      for (int k = 0; k < N_KEYS; k++) begin
        phase[k] <= '0;
      end
      mix_pend <= 1'b0;
    end else begin
      mix_pend <= tick;
      if (tick) begin
        for (int k = 0; k < N_KEYS; k++) begin
          if (keys_db[k]) begin
            phase[k] <= phase[k]
              + PHASE_W'(tune_of(key_idx_e'(k)));
          end else begin
            phase[k] <= '0;
          end
        end
      end
    end
  end

  // Sum of active voices around mid-scale; range never wraps.
  always_comb begin
    mix = MID;
    for (int k = 0; k < N_KEYS; k++) begin
      mix = mix + SAMPLE_W'(voice_term(
        keys_db[k], phase[k][PHASE_W-1]));
    end
  end

  // Output holding register; a sample that cannot be
  // accepted is dropped and flagged.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      sample       <= MID;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (mix_pend) begin
      if (!sample_valid || sample_ready) begin
        sample       <= mix;
        sample_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (sample_valid && sample_ready) begin
      sample_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_tone_gen.sv
// Directed bench for key_tone_gen with DIV=10 and a
// 4-cycle debounce: vector table plus handshake/reset sequences.
module tb_key_tone_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  keys;
  logic [11:0] sample;
  logic        sample_valid;
  logic        sample_ready;
  logic [3:0]  keys_db;
  logic        overrun;

  int n_pass = 0;
  int n_total = 0;

  key_tone_gen #(
    .CLK_HZ       (1000),
    .SAMPLE_HZ    (100),
    .DEBOUNCE_CYC (4),
    .PHASE_W      (24),
    .SAMPLE_W     (12)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .keys         (keys),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .keys_db      (keys_db),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  pat;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input int act,
                     input int exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Edges until sample_valid is seen high, bounded.
  task automatic wait_valid(input string name, input int max,
                            output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!sample_valid && n < max);
    chk({name, "_valid"}, int'(sample_valid), 1);
  endtask

  initial begin
    int n;
    int run0;
    int run1;
    int bad;
    logic [11:0] held;

    vecs[0] = '{4'b0000, 12'd2048};
    vecs[1] = '{4'b0001, 12'd2559};
    vecs[2] = '{4'b0010, 12'd2559};
    vecs[3] = '{4'b0101, 12'd3070};
    vecs[4] = '{4'b0111, 12'd3581};
    vecs[5] = '{4'b1000, 12'd2559};
    vecs[6] = '{4'b1111, 12'd4092};

    rst_n = 1'b0;
    keys = 4'b0000;
    sample_ready = 1'b1;
    step(3);
    chk("rst_valid", int'(sample_valid), 0);
    chk("rst_sample", int'(sample), 2048);
    chk("rst_keys_db", int'(keys_db), 0);
    chk("rst_overrun", int'(overrun), 0);

    // Sync release takes 2 edges, tick after 10 more,
    // sample visible 2 edges after the tick edge... 13 total.
    rst_n = 1'b1;
    wait_valid("first", 40, n);
    chk("first_lat", n, 13);
    chk("first_sample", int'(sample), 2048);
    for (int i = 0; i < 2; i++) begin
      wait_valid("idle", 40, n);
      chk("idle_cadence", n, 10);
      chk("idle_sample", int'(sample), 2048);
    end
    chk("idle_keys_db", int'(keys_db), 0);
    chk("idle_overrun", int'(overrun), 0);

    // Fresh press: every voice starts in its positive half.
    for (int i = 0; i < 7; i++) begin
      keys = 4'b0000;
      step(30);
      wait_valid("vec_rel", 40, n);
      chk("vec_rel_sample", int'(sample), 2048);
      keys = vecs[i].pat;
      step(20);
      wait_valid("vec", 40, n);
      chk("vec_sample", int'(sample), int'(vecs[i].exp));
      chk("vec_keys_db", int'(keys_db), int'(vecs[i].pat));
    end

    // Release all from 1111 and check silence returns.
    keys = 4'b0000;
    step(18);
    wait_valid("release", 40, n);
    chk("release_sample", int'(sample), 2048);
    chk("release_keys_db", int'(keys_db), 0);

    // C4 square: MSB flips after tick 92, wraps after 184.
    keys = 4'b0001;
    run0 = 0;
    for (int i = 0; i < 300; i++) begin
      wait_valid("c4a", 40, n);
      if (sample == 12'd1537) break;
      if (sample == 12'd2559) run0++;
    end
    chk("c4_low_seen", int'(sample), 1537);
    chk("c4_high_run", int'(run0 >= 91 && run0 <= 92), 1);
    run1 = 1;
    for (int i = 0; i < 200; i++) begin
      wait_valid("c4b", 40, n);
      if (sample != 12'd1537) break;
      run1++;
    end
    chk("c4_low_run", run1, 92);
    chk("c4_after_low", int'(sample), 2559);

    // Short glitch on key 1 must be ignored.
    keys = 4'b0000;
    step(30);
    keys = 4'b0010;
    step(2);
    keys = 4'b0000;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (keys_db != 4'b0000) bad++;
    end
    chk("glitch_keys_db", bad, 0);
    wait_valid("glitch", 40, n);
    chk("glitch_sample", int'(sample), 2048);

    // Load and transfer on the same edge keeps valid high.
    wait_valid("hs", 40, n);
    sample_ready = 1'b0;
    step(9);
    chk("hs_hold_valid", int'(sample_valid), 1);
    chk("hs_hold_ovr", int'(overrun), 0);
    sample_ready = 1'b1;
    step(1);
    chk("hs_same_edge_valid", int'(sample_valid), 1);
    chk("hs_same_edge_ovr", int'(overrun), 0);

    // Held sample must survive newer samples while stalled.
    sample_ready = 1'b0;
    held = sample;
    keys = 4'b1111;
    step(10);
    chk("ovr_flag", int'(overrun), 1);
    chk("ovr_valid", int'(sample_valid), 1);
    chk("ovr_frozen", int'(sample), int'(held));
    step(11);
    chk("ovr_frozen2", int'(sample), int'(held));
    sample_ready = 1'b1;
    step(1);
    chk("ovr_drain_valid", int'(sample_valid), 0);
    wait_valid("ovr_next", 40, n);
    chk("ovr_next_lat", n, 8);
    chk("ovr_next_sample", int'(sample), 4092);
    chk("ovr_sticky", int'(overrun), 1);

    // Reset while a sample is held.
    sample_ready = 1'b0;
    wait_valid("mid", 40, n);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(sample_valid), 0);
    chk("mid_rst_sample", int'(sample), 2048);
    chk("mid_rst_keys_db", int'(keys_db), 0);
    chk("mid_rst_overrun", int'(overrun), 0);
    keys = 4'b0000;
    sample_ready = 1'b1;
    step(3);
    rst_n = 1'b1;
    wait_valid("mid_rel", 40, n);
    chk("mid_rel_lat", n, 13);
    chk("mid_rel_sample", int'(sample), 2048);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
